// File: rtl/tap_tempo_estimator_pkg.sv
// Shared constants, FSM encoding and tempo/cycle conversion helper for the tap tempo block.
package tap_tempo_estimator_pkg;

  localparam int BPM_W = 10;
  localparam int DIV_W_DEF = 32;
  localparam int CLK_HZ_DEF = 50_000_000;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } tap_state_t;

  // Clock cycles in one beat at the given tempo (truncated).
  function automatic logic [63:0] cycles_per_beat(input logic [63:0] clk_hz,
                                                  input logic [63:0] bpm);
    return (clk_hz * 64'd60) / bpm;
  endfunction

endpackage

// File: rtl/tap_tempo_estimator_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, DIV_W cycles from start to done.
module seq_divider
#(
  parameter int DIV_W = 32
)
(
  input  logic             Clock,
  input  logic             nReset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] rem_reg, quo_reg, dvs_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DIV_W-1:0] src_rem, src_quo, src_dvs;
  logic [DIV_W-1:0] rem_next, quo_next;
  logic [DIV_W+1:0] trial;

  // The start cycle already performs the first iteration straight from the inputs,
  // so the last bit lands DIV_W-1 cycles later.
  always_comb begin
    src_rem = start ? '0 : rem_reg;
    src_quo = start ? dividend : quo_reg;
    src_dvs = start ? divisor : dvs_reg;
    trial   = {1'b0, src_rem, src_quo[DIV_W-1]} - {2'b00, src_dvs};
    if (trial[DIV_W+1]) begin
      rem_next = {src_rem[DIV_W-2:0], src_quo[DIV_W-1]};
      quo_next = {src_quo[DIV_W-2:0], 1'b0};
    end else begin
      rem_next = trial[DIV_W-1:0];
      quo_next = {src_quo[DIV_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        dvs_reg <= divisor;
        cnt_reg <= CNT_W'(DIV_W - 1);
        busy    <= 1'b1;
      end else if (busy) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/tap_tempo_estimator.sv
// Tap tempo estimator: measures cycles between accepted taps and divides CLK_HZ*60 by them to get BPM.
module tap_tempo_estimator
  import tap_tempo_estimator_pkg::*;
#(
  parameter int unsigned CLK_HZ  = CLK_HZ_DEF,
  parameter int unsigned BPM_MIN = 30,
  parameter int unsigned BPM_MAX = 300,
  parameter int unsigned DIV_W   = DIV_W_DEF
)
(
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Tap,
  output logic [BPM_W-1:0] BPM,
  output logic             Valid,
  output logic             BPM_update,
  output logic             nSync
);

  localparam logic [63:0] MIN_CYC64  = cycles_per_beat(64'(CLK_HZ), 64'(BPM_MAX));
  localparam logic [63:0] MAX_CYC64  = cycles_per_beat(64'(CLK_HZ), 64'(BPM_MIN));
  localparam logic [63:0] DIVIDEND64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [DIV_W-1:0] MIN_CYC  = MIN_CYC64[DIV_W-1:0];
  localparam logic [DIV_W-1:0] MAX_CYC  = MAX_CYC64[DIV_W-1:0];
  localparam logic [DIV_W-1:0] DIVIDEND = DIVIDEND64[DIV_W-1:0];

  // The divider must be idle again before the earliest possible next accepted tap.
  if (MIN_CYC64 <= 64'(DIV_W) + 64'd2 || (DIVIDEND64 >> DIV_W) != 64'd0) begin : g_param_check
    $error("tap_tempo_estimator: need MIN_CYC > DIV_W+2 and CLK_HZ*60 within DIV_W bits");
  end

  tap_state_t       state_reg;
  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] divisor_reg;
  logic             start_reg;
  logic             tap_accept, tap_measure;
  logic [DIV_W-1:0] quotient;
  logic             div_busy, div_done;

  always_comb begin
    tap_measure = Tap && (state_reg == ARMED) && (cnt_reg >= MIN_CYC);
    tap_accept  = (Tap && (state_reg == IDLE)) || tap_measure;
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      divisor_reg <= '0;
      start_reg   <= 1'b0;
      nSync       <= 1'b1;
      BPM         <= '0;
      Valid       <= 1'b0;
      BPM_update  <= 1'b0;
    end else begin
      nSync      <= !tap_accept;
      start_reg  <= tap_measure && !div_busy;
      BPM_update <= div_done;
      if (tap_measure)
        divisor_reg <= cnt_reg;
      // Saturate at the timeout value so a long idle period never wraps.
      if (tap_accept)
        cnt_reg <= DIV_W'(1);
      else if (cnt_reg < MAX_CYC)
        cnt_reg <= cnt_reg + DIV_W'(1);
      case (state_reg)
        IDLE:    if (Tap) state_reg <= ARMED;
        ARMED:   if (!Tap && cnt_reg == MAX_CYC) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (div_done) begin
        BPM   <= (|quotient[DIV_W-1:BPM_W]) ? '1 : quotient[BPM_W-1:0];
        Valid <= 1'b1;
      end
    end
  end

  seq_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .Clock    (Clock),
    .nReset   (nReset),
    .start    (start_reg),
    .dividend (DIVIDEND),
    .divisor  (divisor_reg),
    .quotient (quotient),
    .busy     (div_busy),
    .done     (div_done)
  );

endmodule
